// File: rtl/user_arb_pkg.sv
// user_arb_pkg
// Shared constants and types for the user request arbiter.
//   N_REQ        : default number of requesters
//   MAX_HOLD_DEF : default maximum consecutive grant cycles per owner
//   arb_state_t  : arbiter FSM state encoding
package user_arb_pkg;

  localparam int N_REQ        = 12;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/user_req_arbiter_rr_pick.sv
// rr_pick
// Purely combinational rotating priority encoder. Returns the first set bit
// of req, searching upward from ptr and wrapping past N-1 back to 0.
// Ports:
//   req         in  N    : request vector
//   ptr         in  ID_W : index with the highest priority
//   pick_onehot out N    : one-hot winner, zero when nothing is requested
//   pick_id     out ID_W : winner index, zero when nothing is requested
//   pick_any    out 1    : at least one request is present
module rr_pick #(
  parameter int N    = 12,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    pick_onehot,
  output logic [ID_W-1:0] pick_id,
  output logic            pick_any
);

  // One spare bit so ptr + offset can exceed N-1 before being folded back.
  logic [ID_W:0] slot;
  logic          found;

  always_comb begin
    pick_onehot = '0;
    pick_id     = '0;
    found       = 1'b0;
    slot        = '0;
    for (int i = 0; i < N; i++) begin
      slot = {1'b0, ptr} + (ID_W+1)'(i);
      if (slot >= (ID_W+1)'(N)) begin
        slot = slot - (ID_W+1)'(N);
      end
      if (!found && req[slot[ID_W-1:0]]) begin
        found   = 1'b1;
        pick_id = slot[ID_W-1:0];
      end
    end
    if (found) begin
      pick_onehot[pick_id] = 1'b1;
    end
  end

  assign pick_any = |req;

endmodule

// File: rtl/user_req_arbiter.sv
// user_req_arbiter
// Round-robin arbiter sharing one downstream resource among N level-sensitive
// requesters. One owner at a time; the grant is held while the owner keeps
// requesting, and is force-released after MAX_HOLD consecutive cycles. Every
// change of owner passes through one dead GAP cycle with no grant.
// Ports:
//   clk       in  1    : clock, rising edge
//   rst       in  1    : asynchronous active-high reset
//   user_req  in  N    : level request per requester
//   gnt       out N    : one-hot grant or zero
//   gnt_valid out 1    : gnt is non-zero
//   gnt_id    out ID_W : index of current/last owner (held while idle)
//   any_req   out 1    : registered OR of user_req
//   preempt   out 1    : one-cycle pulse in the GAP after a hold timeout
module user_req_arbiter
  import user_arb_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    user_req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_req,
  output logic            preempt
);

  localparam int               CNT_W     = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N - 1);

  arb_state_t       state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [N-1:0]     pick_onehot;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;

  logic             owner_req;
  logic             hold_done;
  logic             release_now;

  rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req         (user_req),
    .ptr         (ptr),
    .pick_onehot (pick_onehot),
    .pick_id     (pick_id),
    .pick_any    (pick_any)
  );

  assign owner_req   = user_req[gnt_id];
  assign hold_done   = (hold_cnt == HOLD_LAST);
  assign release_now = !owner_req || hold_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      any_req   <= 1'b0;
      preempt   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      any_req <= |user_req;
      preempt <= 1'b0;
      case (state)
        // IDLE and GAP select identically; GAP differs only in that ptr has
        // just moved past the previous owner, making it lowest priority.
        IDLE, GAP: begin
          if (pick_any) begin
            state     <= GRANT;
            gnt       <= pick_onehot;
            gnt_valid <= 1'b1;
            gnt_id    <= pick_id;
            hold_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= GAP;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= (gnt_id == ID_LAST) ? '0 : gnt_id + ID_W'(1);
            // Releasing while the owner still requests can only be a
            // timeout; a drop on the timeout edge is a normal release.
            preempt   <= owner_req;
          end else if (!hold_done) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt));
  a_valid_match : assert property (@(posedge clk) disable iff (rst)
    gnt_valid == (|gnt));
  a_preempt_gap : assert property (@(posedge clk) disable iff (rst)
    preempt |-> !gnt_valid);

endmodule

// File: tb/tb_user_req_arbiter.sv
// Scoreboard bench for user_req_arbiter: directed stimulus pushes the
// expected grant transactions (owner, length, preempt at end); a monitor
// reconstructs grants from the outputs and pops/compares them.
module tb_user_req_arbiter;

  logic        clk;
  logic        rst;
  logic [11:0] user_req;
  logic [11:0] gnt;
  logic        gnt_valid;
  logic [3:0]  gnt_id;
  logic        any_req;
  logic        preempt;

  user_req_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .user_req  (user_req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .any_req   (any_req),
    .preempt   (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int id;
    int len;
    bit pre;
  } txn_t;

  txn_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   act_q = 1'b0;
  int   cur_id = 0;
  int   cur_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_grant(input int id, input int len, input bit pre);
    txn_t t;
    t.id  = id;
    t.len = len;
    t.pre = pre;
    sb.push_back(t);
  endtask

  task automatic close_txn(input bit pre_seen);
    txn_t e;
    if (sb.size() == 0) begin
      check("unexpected_grant_id", cur_id, -1);
    end else begin
      e = sb.pop_front();
      check("grant_id", cur_id, e.id);
      check("grant_len", cur_len, e.len);
      check("grant_preempt", int'(pre_seen), int'(e.pre));
    end
    act_q = 1'b0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (act_q) close_txn(preempt);
      end else if (gnt_valid) begin
        check("gnt_onehot", int'(gnt), 1 << gnt_id);
        if (act_q && (int'(gnt_id) != cur_id)) close_txn(preempt);
        if (!act_q) begin
          act_q   = 1'b1;
          cur_id  = int'(gnt_id);
          cur_len = 1;
        end else begin
          cur_len++;
        end
      end else begin
        check("gnt_zero_when_invalid", int'(gnt), 0);
        if (act_q) close_txn(preempt);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    user_req = '0;
    cyc(2);
    rst = 1'b0;

    // Reset state
    check("rst_gnt", int'(gnt), 0);
    check("rst_gnt_valid", int'(gnt_valid), 0);
    check("rst_gnt_id", int'(gnt_id), 0);
    check("rst_any_req", int'(any_req), 0);
    check("rst_preempt", int'(preempt), 0);

    // Single request: 0x004 for 5 cycles
    expect_grant(2, 5, 1'b0);
    user_req = 12'h004;
    check("any_req_not_comb", int'(any_req), 0);
    cyc(1);
    check("single_any_req", int'(any_req), 1);
    check("single_gnt", int'(gnt), 'h004);
    cyc(4);
    user_req = '0;
    cyc(1);
    check("single_gap_valid", int'(gnt_valid), 0);
    check("single_any_req_off", int'(any_req), 0);
    cyc(1);
    check("single_id_held", int'(gnt_id), 2);

    // Round-robin fairness with all requests held
    reset_pulse();
    for (int k = 0; k < 13; k++) expect_grant(k % 12, 16, 1'b1);
    user_req = 12'hFFF;
    cyc(17);
    check("fair_first_preempt", int'(preempt), 1);
    cyc(204);
    user_req = '0;
    cyc(3);

    // Pointer wrap: 11 then 0 then 11
    reset_pulse();
    expect_grant(11, 16, 1'b1);
    expect_grant(0, 16, 1'b1);
    expect_grant(11, 3, 1'b0);
    user_req = 12'h800;
    cyc(1);
    user_req = 12'h801;
    cyc(36);
    user_req = '0;
    cyc(3);

    // Drop coincides with timeout edge: normal release
    expect_grant(1, 16, 1'b0);
    user_req = 12'h002;
    cyc(16);
    user_req = '0;
    cyc(1);
    check("coinc_preempt", int'(preempt), 0);
    check("coinc_gap", int'(gnt_valid), 0);
    cyc(2);

    // Non-owner churn while 3 owns the grant
    expect_grant(3, 7, 1'b0);
    expect_grant(7, 1, 1'b0);
    user_req = 12'h008;
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      user_req = (i % 2 == 0) ? 12'h098 : 12'h008;
      cyc(1);
      check("churn_gnt", int'(gnt), 'h008);
    end
    user_req = 12'h010;
    cyc(1);
    check("churn_gap", int'(gnt_valid), 0);
    user_req = 12'h080;
    cyc(1);
    check("churn_next_id", int'(gnt_id), 7);
    user_req = '0;
    cyc(3);

    // Mid-grant asynchronous reset
    expect_grant(5, 2, 1'b0);
    expect_grant(4, 2, 1'b0);
    user_req = 12'h020;
    cyc(3);
    check("pre_rst_gnt", int'(gnt), 'h020);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gnt", int'(gnt), 0);
    check("async_rst_valid", int'(gnt_valid), 0);
    user_req = 12'h030;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    user_req = '0;
    cyc(3);

    check("sb_drained", sb.size(), 0);
    check("no_open_grant", int'(act_q), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/user_req_arbiter.md
# user_req_arbiter

Round-robin arbiter that shares one downstream resource among 12 user request lines. It grants exactly one requester at a time, holds the grant while that request stays asserted, and force-releases the grant after a bounded hold time. It also exports a registered "any request pending" flag, which is the OR-reduction of the request vector. The block sits between the user request inputs and the shared resource's select/enable logic.

## Interface
- `N`, 12: number of requesters.
- `MAX_HOLD`, 16: maximum consecutive grant cycles per requester before forced release (≥2).
- `ID_W`, $clog2(N): width of the grant index.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `user_req` in N: level request, one bit per requester. Synchronous to `clk`.
- `gnt` out N: one-hot grant, or all zeros.
- `gnt_valid` out 1: high whenever `gnt` is non-zero.
- `gnt_id` out ID_W: index of the granted requester. Holds its last value when `gnt_valid` is 0.
- `any_req` out 1: registered `|user_req`.
- `preempt` out 1: one-cycle pulse on a forced release (hold timeout).

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
  - GAP: one dead cycle with `gnt` = 0 between owners.
- Round-robin pointer `ptr` (ID_W bits):
  - Selection picks the first set bit of `user_req`, searching `ptr`, `ptr+1`, … `N-1`, `0`, … `ptr-1`.
  - `ptr` resets to 0.
- IDLE:
  - If `user_req` is non-zero: go to GRANT, register the selected one-hot into `gnt`, `gnt_id` = selected index, hold counter = 0.
  - Otherwise stay in IDLE.
- GRANT:
  - Release condition: `user_req[gnt_id]` = 0, or hold counter = MAX_HOLD-1.
  - On release:
    - go to GAP and set `gnt` = 0;
    - set `ptr` = `gnt_id`+1, wrapping `N-1` → 0;
    - pulse `preempt` only if the release was a timeout with the request still high.
  - Otherwise stay in GRANT and increment the hold counter (saturating).
- GAP:
  - If `user_req` is non-zero: select using the updated `ptr` and go to GRANT. The previous owner is eligible, but it has the lowest priority.
  - Otherwise go to IDLE.
- Requests that appear or disappear on non-owner lines during GRANT have no effect on the current grant.
- `any_req` is the registered `|user_req`, independent of FSM state.

## Timing
- Reset values:
  - state = IDLE, `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `any_req` = 0, `preempt` = 0, `ptr` = 0, hold counter = 0.
- Grant latency:
  - `user_req` sampled at edge k → `gnt` high after edge k (visible in cycle k+1).
  - Worst case from GRANT, including GAP: owner release sampled at edge k → GAP in cycle k+1 → next `gnt` in cycle k+2.
- Timeout: a continuously requesting owner holds `gnt` for exactly MAX_HOLD cycles. `preempt` is high in the first GAP cycle.
- Owner drops its request at edge k: `gnt` is 0 from cycle k+1. There is no early release within the same cycle.
- `any_req` lags `user_req` by one cycle.
- Simultaneous events:
  - A timeout and owner drop on the same edge counts as a normal release, with `preempt` = 0.
  - Any number of simultaneous new requests: only the round-robin winner is granted, and the others wait.
- Asserting `rst` mid-grant clears `gnt` immediately (asynchronously). After reset is released, the first selection starts from `ptr` = 0.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `user_arb_pkg`:
  - constants N_REQ = 12 and MAX_HOLD_DEF = 16;
  - enum `arb_state_t` {IDLE, GRANT, GAP}.
- One sub-module, `rr_pick`: a purely combinational rotating priority encoder.
  - Inputs: `req[N]`, `ptr[ID_W]`.
  - Outputs: `pick_onehot[N]`, `pick_id[ID_W]`, `pick_any`.
- The top level holds the FSM, the hold counter, `ptr`, and the output registers.

## Test plan
- Reset and single request:
  - Stimulus: `rst` pulse, then `user_req` = 0x004 for 5 cycles, then 0.
  - Response: `gnt` = 0x004 and `gnt_id` = 2 for 5 cycles starting one cycle after the request; then one GAP cycle, then IDLE.
  - `any_req` follows `user_req` delayed by one cycle.
- Round-robin fairness:
  - Stimulus: `user_req` = 0xFFF held constantly.
  - Response: grants in the order 0, 1, …, 11, 0. Each grant lasts 16 cycles, separated by one GAP cycle, with a `preempt` pulse on every GAP.
- Pointer wrap:
  - Stimulus: owner 11 releases while `user_req` = 0x801.
  - Response: next grant goes to requester 0, then to requester 11.
- Drop/timeout coincidence:
  - Stimulus: owner drops its request on the same edge as the hold counter reaching 15.
  - Response: GAP follows, with `preempt` = 0.
- Non-owner churn:
  - Stimulus: while 3 owns the grant, toggle bits 4 and 7 every cycle.
  - Response: `gnt` stays 0x008 until 3 releases; the next grant goes to 4, if bit 4 is set at the GAP edge, otherwise to 7.
- Mid-grant reset:
  - Stimulus: assert `rst` asynchronously while `gnt` = 0x020.
  - Response: `gnt` = 0 with no clock edge required. After release, with `user_req` = 0x030, requester 4 is granted first because `ptr` = 0.
